// File: rtl/cpu_port_responder_if.sv
// Host-side stream bundle: capture FIFO output stream and p2 load stream.
interface cpu_port_responder_if;
  localparam int unsigned DW = 16;

  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;

  // Responder side
  modport slave (
    output out_data, out_valid, in_ready,
    input  out_ready, in_data, in_valid
  );

  // Host side
  modport master (
    input  out_data, out_valid, in_ready,
    output out_ready, in_data, in_valid
  );
endinterface

// File: rtl/cpu_port_responder.sv
// CPU port responder: captures p1 changes into a FIFO for the host, loads p2
// from the host, and watches the program counter for a breakpoint address.
module cpu_port_responder #(
  parameter int unsigned DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [15:0]           p1,
  input  logic [15:0]           pc,
  output logic [15:0]           p2,
  input  logic [15:0]           brk_addr,
  input  logic                  brk_en,
  output logic                  brk_hit,
  output logic [7:0]            hit_count,
  output logic                  ovf,
  cpu_port_responder_if.slave   host
);

  localparam int unsigned DW    = 16;
  localparam int unsigned HW    = 8;
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [DW-1:0]    mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             out_valid_q, out_valid_d;
  logic             ovf_q, ovf_d;
  logic [DW-1:0]    last_p1_q, last_p1_d;
  logic [DW-1:0]    last_pc_q, last_pc_d;
  logic [DW-1:0]    p2_q, p2_d;
  logic             brk_hit_q, brk_hit_d;
  logic [HW-1:0]    hit_count_q, hit_count_d;

  logic push, pop, full, wr_en, fetch;

  // Next-state logic for FIFO bookkeeping, p2 load and breakpoint watch
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    ovf_d       = ovf_q;
    p2_d        = p2_q;
    hit_count_d = hit_count_q;
    last_p1_d   = p1;
    last_pc_d   = pc;

    push  = (p1 != last_p1_q);
    pop   = out_valid_q & host.out_ready;
    full  = (count_q == CNT_W'(DEPTH));
    // A full FIFO still accepts a push when a pop frees a slot on the same edge
    wr_en = push & (~full | pop);

    // Pointers wrap naturally since DEPTH is a power of two
    if (wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)   rd_ptr_d = rd_ptr_q + PTR_W'(1);

    if (wr_en && !pop)      count_d = count_q + CNT_W'(1);
    else if (!wr_en && pop) count_d = count_q - CNT_W'(1);

    if (push && full && !pop) ovf_d = 1'b1;

    out_valid_d = (count_d != '0);

    if (host.in_valid) p2_d = host.in_data;

    fetch     = (pc != last_pc_q);
    brk_hit_d = brk_en & fetch & (pc == brk_addr);
    if (brk_hit_d && (hit_count_q != {HW{1'b1}})) hit_count_d = hit_count_q + HW'(1);
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
      last_p1_q   <= '0;
      last_pc_q   <= '0;
      p2_q        <= '0;
      brk_hit_q   <= 1'b0;
      hit_count_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      ovf_q       <= ovf_d;
      last_p1_q   <= last_p1_d;
      last_pc_q   <= last_pc_d;
      p2_q        <= p2_d;
      brk_hit_q   <= brk_hit_d;
      hit_count_q <= hit_count_d;
    end
  end

  // FIFO storage; contents need no reset since count gates visibility
  always_ff @(posedge clk) begin
    if (!rst && wr_en) mem_q[wr_ptr_q] <= p1;
  end

  assign host.out_data  = mem_q[rd_ptr_q];
  assign host.out_valid = out_valid_q;
  assign host.in_ready  = ~rst;
  assign p2             = p2_q;
  assign brk_hit        = brk_hit_q;
  assign hit_count      = hit_count_q;
  assign ovf            = ovf_q;

endmodule

// File: tb/tb_cpu_port_responder.sv
// Scoreboard bench for cpu_port_responder: driver queues expected FIFO words,
// a negedge monitor pops and compares them as the host accepts words.
module tb_cpu_port_responder;
  localparam int unsigned DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] p1, pc, p2, brk_addr;
  logic        brk_en, brk_hit, ovf;
  logic [7:0]  hit_count;

  cpu_port_responder_if bus();

  cpu_port_responder #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .p1        (p1),
    .pc        (pc),
    .p2        (p2),
    .brk_addr  (brk_addr),
    .brk_en    (brk_en),
    .brk_hit   (brk_hit),
    .hit_count (hit_count),
    .ovf       (ovf),
    .host      (bus)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] exp_q[$];
  logic [15:0] m_last_p1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Predict the FIFO effect of the upcoming edge, then advance one cycle
  task automatic tick();
    if (rst) begin
      exp_q.delete();
      m_last_p1 = '0;
    end else begin
      if (p1 != m_last_p1) begin
        if (exp_q.size() < DEPTH || (bus.out_ready && exp_q.size() > 0))
          exp_q.push_back(p1);
      end
      m_last_p1 = p1;
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: every accepted head word must match the scoreboard front
  logic [15:0] mon_exp;
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard_pop: got 0x%0h expected no word", bus.out_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (bus.out_data !== mon_exp) begin
          n_fail++;
          $display("FAIL scoreboard_pop: got 0x%0h expected 0x%0h", bus.out_data, mon_exp);
        end
      end
    end
  end

  logic [15:0] pc_seq [5];
  logic        hit_seq[5];

  initial begin
    rst = 1'b1; p1 = '0; pc = '0; brk_addr = '0; brk_en = 1'b0;
    bus.out_ready = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0;
    m_last_p1 = '0;
    pc_seq  = '{16'h000F, 16'h0010, 16'h0010, 16'h0011, 16'h0010};
    hit_seq = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

    // Reset state
    #1 check("in_ready_during_reset", 32'(bus.in_ready), 32'd0);
    tick(); tick();
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_p2", 32'(p2), 32'd0);
    check("rst_brk_hit", 32'(brk_hit), 32'd0);
    check("rst_hit_count", 32'(hit_count), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    rst = 1'b0;
    #1 check("in_ready_run", 32'(bus.in_ready), 32'd1);

    // Basic capture and pop
    p1 = 16'h0000; tick();
    check("p1_zero_no_push", 32'(bus.out_valid), 32'd0);
    p1 = 16'h1234; tick();
    check("first_push_latency", 32'(bus.out_valid), 32'd1);
    p1 = 16'h1234; tick();
    p1 = 16'hBEEF; tick();
    check("two_entries_head", 32'(bus.out_data), 32'h1234);
    bus.out_ready = 1'b1; tick();
    check("after_pop_head", 32'(bus.out_data), 32'hBEEF);
    check("after_pop_valid", 32'(bus.out_valid), 32'd1);
    tick();
    check("drained_valid", 32'(bus.out_valid), 32'd0);
    bus.out_ready = 1'b0;

    // Overflow: 10 values into 8 slots
    for (int i = 0; i < 10; i++) begin
      p1 = 16'h1000 + 16'(i); tick();
      if (i == 7) check("full_no_ovf_yet", 32'(ovf), 32'd0);
      if (i == 8) check("ovf_on_drop", 32'(ovf), 32'd1);
    end
    check("ovf_head", 32'(bus.out_data), 32'h1000);
    check("ovf_sticky", 32'(ovf), 32'd1);
    bus.out_ready = 1'b1;
    repeat (8) tick();
    check("ovf_drained_valid", 32'(bus.out_valid), 32'd0);
    check("ovf_after_drain", 32'(ovf), 32'd1);
    bus.out_ready = 1'b0;

    // Full FIFO with simultaneous push and pop
    rst = 1'b1; p1 = '0; tick(); rst = 1'b0;
    check("ovf_cleared", 32'(ovf), 32'd0);
    for (int i = 0; i < 8; i++) begin
      p1 = 16'h2000 + 16'(i); tick();
    end
    check("full_ovf", 32'(ovf), 32'd0);
    check("full_head", 32'(bus.out_data), 32'h2000);
    p1 = 16'h7777; bus.out_ready = 1'b1; tick();
    check("pushpop_ovf", 32'(ovf), 32'd0);
    check("pushpop_head", 32'(bus.out_data), 32'h2001);
    repeat (7) tick();
    check("pushpop_last_word", 32'(bus.out_data), 32'h7777);
    check("pushpop_last_valid", 32'(bus.out_valid), 32'd1);
    tick();
    check("pushpop_empty", 32'(bus.out_valid), 32'd0);
    check("pushpop_ovf_end", 32'(ovf), 32'd0);
    bus.out_ready = 1'b0;

    // p2 load and hold
    bus.in_valid = 1'b1; bus.in_data = 16'hA5A5; tick();
    bus.in_valid = 1'b0; bus.in_data = 16'h1111;
    check("p2_load", 32'(p2), 32'hA5A5);
    tick();
    check("p2_hold", 32'(p2), 32'hA5A5);
    rst = 1'b1; p1 = '0; tick(); rst = 1'b0;
    check("p2_reset", 32'(p2), 32'd0);

    // Breakpoint watch
    brk_en = 1'b1; brk_addr = 16'h0010;
    for (int i = 0; i < 5; i++) begin
      pc = pc_seq[i]; tick();
      check($sformatf("brk_hit_seq%0d", i), 32'(brk_hit), 32'(hit_seq[i]));
    end
    check("hit_count_two", 32'(hit_count), 32'd2);
    for (int k = 1; k <= 300; k++) begin
      pc = 16'h0011; tick();
      pc = 16'h0010; tick();
      if (k == 252) check("hit_count_254", 32'(hit_count), 32'd254);
    end
    check("hit_count_sat", 32'(hit_count), 32'd255);
    pc = 16'h0011; tick();
    brk_en = 1'b0; pc = 16'h0010; tick();
    check("brk_disabled", 32'(brk_hit), 32'd0);
    check("brk_disable_keeps_count", 32'(hit_count), 32'd255);
    brk_en = 1'b1;

    // Reset mid-operation
    rst = 1'b1; pc = '0; tick(); rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      p1 = 16'h3000 + 16'(i); tick();
    end
    for (int k = 0; k < 7; k++) begin
      pc = 16'h0011; tick();
      pc = 16'h0010; tick();
    end
    check("pre_reset_hits", 32'(hit_count), 32'd7);
    check("pre_reset_valid", 32'(bus.out_valid), 32'd1);
    rst = 1'b1; p1 = '0; pc = '0; bus.in_valid = 1'b1; bus.in_data = 16'hFFFF;
    #1 check("mid_reset_in_ready", 32'(bus.in_ready), 32'd0);
    tick();
    check("mid_reset_valid", 32'(bus.out_valid), 32'd0);
    check("mid_reset_hit_count", 32'(hit_count), 32'd0);
    check("mid_reset_ovf", 32'(ovf), 32'd0);
    check("mid_reset_p2", 32'(p2), 32'd0);
    rst = 1'b0; bus.in_valid = 1'b0; brk_addr = 16'h0000;
    tick();
    check("pc_zero_first_edge", 32'(brk_hit), 32'd0);
    check("post_reset_empty", 32'(bus.out_valid), 32'd0);

    // Nonzero pc and p1 on the first edge after reset
    rst = 1'b1; tick(); rst = 1'b0;
    brk_addr = 16'h0020; pc = 16'h0020; p1 = 16'h5555; tick();
    check("pc_nonzero_first_edge", 32'(brk_hit), 32'd1);
    check("p1_nonzero_first_edge", 32'(bus.out_valid), 32'd1);
    bus.out_ready = 1'b1; tick();
    bus.out_ready = 1'b0;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/cpu_port_responder.md
CPU_PORT_RESPONDER -- requirements
Module: cpu_port_responder

Interface
REQ-001 Parameter DEPTH, default 8, output-capture FIFO depth in words (power of two, 2..64) SHALL be supported.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high; SHALL be sampled only on the rising edge of clk.
REQ-004 p1  input  16  CPU output port value, SHALL be sampled every cycle.
REQ-005 pc  input  16  CPU program counter, SHALL be sampled every cycle.
REQ-006 p2  output  16  CPU input port value, SHALL be a registered output.
REQ-007 out_data  output  16  FIFO head word.
REQ-008 out_valid  output  1  FIFO non-empty.
REQ-009 out_ready  input  1  host accepts head word.
REQ-010 in_data  input  16  host word for p2.
REQ-011 in_valid  input  1  in_data valid.
REQ-012 in_ready  output  1  responder accepts in_data.
REQ-013 brk_addr  input  16  watch address.
REQ-014 brk_en  input  1  watch enable.
REQ-015 brk_hit  output  1  one-cycle watch pulse.
REQ-016 hit_count  output  8  saturating watch-hit counter.
REQ-017 ovf  output  1  sticky FIFO-overflow flag.

Function
REQ-018 The block SHALL hold last_p1 (16 b) and push p1 into the FIFO on any edge where p1 != last_p1; last_p1 SHALL update to p1 every non-reset edge.
REQ-019 A pushed word SHALL appear at out_data with out_valid=1 after the edge that sampled it (1-cycle latency) when the FIFO was empty.
REQ-020 A pop SHALL occur on an edge where out_valid=1 and out_ready=1; out_data SHALL then show the next entry after that edge.
REQ-021 out_data SHALL be don't-care while out_valid=0; out_ready while empty SHALL have no effect.
REQ-022 Occupancy count SHALL range 0..DEPTH; read/write pointers SHALL wrap modulo DEPTH.
REQ-023 Push while full and no pop on the same edge: the word SHALL be dropped, contents unchanged, ovf set to 1.
REQ-024 Push and pop on the same edge (any occupancy including full): both SHALL occur, count unchanged, ovf unchanged.
REQ-025 ovf SHALL remain 1 until reset.
REQ-026 in_ready SHALL be 1 in every non-reset cycle; on an edge with in_valid=1, p2 SHALL load in_data (visible the next cycle); otherwise p2 SHALL hold.
REQ-027 The block SHALL hold last_pc (16 b); a fetch event SHALL be an edge with pc != last_pc; last_pc SHALL update to pc every non-reset edge.
REQ-028 brk_hit SHALL be 1 for exactly the cycle following an edge with brk_en=1, a fetch event and pc == brk_addr; 0 otherwise.
REQ-029 pc held constant at brk_addr across several cycles SHALL produce a single hit.
REQ-030 hit_count SHALL increment by 1 on each brk_hit, saturating at 255 with no wrap.
REQ-031 brk_addr/brk_en changes SHALL take effect on the next edge; they SHALL not clear hit_count.

Reset
REQ-032 On an edge with rst=1 the following SHALL be cleared to 0: p2, out_valid, count, both pointers, last_p1, last_pc, brk_hit, hit_count and ovf; in_ready SHALL be 0 while rst=1.
REQ-033 Reset mid-operation SHALL discard FIFO contents with no pop reported; in_valid during reset SHALL be ignored.
REQ-034 On the first edge after reset, p1=0 SHALL not push and a nonzero p1 SHALL push; pc=0 SHALL not count as a fetch event, and a nonzero pc SHALL count as one.

Verification
REQ-035 Reset, then p1 0x0000->0x1234->0x1234->0xBEEF with out_ready=0 -> 2 entries, out_data=0x1234; pop -> 0xBEEF; pop -> out_valid=0.
REQ-036 DEPTH=8, out_ready=0, 10 distinct p1 values -> count=8, entries are the first 8 values, ovf=1; drain all 8 -> order preserved, ovf still 1.
REQ-037 Full FIFO, pop and new p1 value on the same edge -> count stays 8, ovf stays 0, the new value is last out.
REQ-038 in_valid=1, in_data=0xA5A5 for one cycle -> p2=0xA5A5 the next cycle and held after in_valid drops; rst pulse -> p2=0x0000.
REQ-039 brk_en=1, brk_addr=0x0010, pc sequence 0x000F,0x0010,0x0010,0x0011,0x0010 -> brk_hit pulses twice, hit_count=2; 300 further hits -> hit_count=255.
REQ-040 Reset asserted with 5 entries queued and hit_count=7 -> next cycle out_valid=0, hit_count=0, ovf=0, in_ready=0 during reset.
